game_display_renderer: RTL

- Consumer end of the game-logic outputs: turns block position, overlap flag and game status into pixel writes for the 160x120 VGA adapter.
- On each game-logic `sync` pulse it erases the block at its previous x and redraws it at the current x, on the current row.
- It clears or fills the whole screen on reset and on game-status changes.
- It sits between the game-logic toplevel and the VGA adapter.

---
 rtl/game_display_renderer_pkg.sv | 41 ++++
 rtl/game_display_renderer_if.sv | 29 ++
 rtl/game_display_renderer_rect_sweeper.sv | 68 ++++++
 rtl/game_display_renderer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/game_display_renderer_pkg.sv
// Shared encodings and constants for the game display renderer and the
// gameplay control block that feeds it.
package game_display_renderer_pkg;

   // Game status as produced by gameplay_control
   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_PLAY  = 2'd1,
      ST_LOSE  = 2'd2,
      ST_WIN   = 2'd3
   } game_status_t;

   // Renderer sequencing states
   typedef enum logic [2:0] {
      RS_CLEAR = 3'd0,
      RS_IDLE  = 3'd1,
      RS_ERASE = 3'd2,
      RS_DRAW  = 3'd3,
      RS_FILL  = 3'd4,
      RS_DONE  = 3'd5
   } rstate_t;

   // Screen and block geometry
   localparam int DEF_SCR_W   = 160;
   localparam int DEF_SCR_H   = 120;
   localparam int DEF_BLOCK_W = 16;
   localparam int DEF_BLOCK_H = 4;

   // Colours (3-bit RGB)
   localparam logic [2:0] DEF_COL_BG   = 3'b000;
   localparam logic [2:0] DEF_COL_HIT  = 3'b010;
   localparam logic [2:0] DEF_COL_MISS = 3'b100;
   localparam logic [2:0] DEF_COL_WIN  = 3'b010;
   localparam logic [2:0] DEF_COL_LOSE = 3'b100;

   // True for every state that owns a running (or about to start) sweep
   function automatic logic is_sweep_state(input rstate_t s);
      return (s == RS_CLEAR) || (s == RS_ERASE) || (s == RS_DRAW) || (s == RS_FILL);
   endfunction

endpackage

// File: rtl/game_display_renderer_if.sv
// Bundle between the game-logic side (master) and the renderer (slave):
// position/status inputs towards the renderer, pixel stream and status back.
interface game_display_renderer_if;
   import game_display_renderer_pkg::*;

   logic         sync;
   logic [7:0]   x;
   logic [7:0]   prev_x;
   logic [6:0]   y;
   logic         o;
   game_status_t game_status;
   logic [7:0]   vga_x;
   logic [6:0]   vga_y;
   logic [2:0]   colour;
   logic         plot;
   logic         busy;
   logic         overrun;

   modport master (
      output sync, x, prev_x, y, o, game_status,
      input  vga_x, vga_y, colour, plot, busy, overrun
   );

   modport slave (
      input  sync, x, prev_x, y, o, game_status,
      output vga_x, vga_y, colour, plot, busy, overrun
   );

endinterface

// File: rtl/game_display_renderer_rect_sweeper.sv
// Row-major rectangle walker: one pixel coordinate per cycle. The first
// pixel is presented combinationally in the start cycle so the caller's
// output register sees it one edge later; the rest follow from counters.
module rect_sweeper (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [8:0] org_x,
   input  logic [8:0] org_y,
   input  logic [8:0] size_w,
   input  logic [8:0] size_h,
   output logic [8:0] px,
   output logic [8:0] py,
   output logic       valid,
   output logic       last
);

   logic       run;
   logic [8:0] ox_r, oy_r, w_r, h_r, cx_r, cy_r;
   logic [8:0] cur_ox, cur_oy, cur_w, cur_h, cur_cx, cur_cy;
   logic       x_end;

   // Select live geometry: fresh inputs in the start cycle, latched otherwise
   always_comb begin
      if (start) begin
         cur_ox = org_x;
         cur_oy = org_y;
         cur_w  = size_w;
         cur_h  = size_h;
         cur_cx = '0;
         cur_cy = '0;
      end else begin
         cur_ox = ox_r;
         cur_oy = oy_r;
         cur_w  = w_r;
         cur_h  = h_r;
         cur_cx = cx_r;
         cur_cy = cy_r;
      end
      x_end = (cur_cx == cur_w - 9'd1);
      valid = start | run;
      last  = valid && x_end && (cur_cy == cur_h - 9'd1);
      px    = cur_ox + cur_cx;
      py    = cur_oy + cur_cy;
   end

   // Sweep-active flag; cleared by reset so an aborted sweep stops at once
   always_ff @(posedge clk) begin
      if (reset) begin
         run <= 1'b0;
      end else begin
         run <= valid && !last;
      end
   end

   // Geometry latch and x-fastest offset counters
   always_ff @(posedge clk) begin
      if (valid) begin
         ox_r <= cur_ox;
         oy_r <= cur_oy;
         w_r  <= cur_w;
         h_r  <= cur_h;
         cx_r <= x_end ? 9'd0 : cur_cx + 9'd1;
         cy_r <= x_end ? cur_cy + 9'd1 : cur_cy;
      end
   end

endmodule

// File: rtl/game_display_renderer.sv
// Turns game-logic block positions and status into a VGA pixel-write
// stream: full-screen clear/fill sweeps and per-sync erase/redraw of the
// block, all through a single rectangle sweeper.
module game_display_renderer
   import game_display_renderer_pkg::*;
#(
   parameter int         SCR_W    = DEF_SCR_W,
   parameter int         SCR_H    = DEF_SCR_H,
   parameter int         BLOCK_W  = DEF_BLOCK_W,
   parameter int         BLOCK_H  = DEF_BLOCK_H,
   parameter logic [2:0] COL_BG   = DEF_COL_BG,
   parameter logic [2:0] COL_HIT  = DEF_COL_HIT,
   parameter logic [2:0] COL_MISS = DEF_COL_MISS,
   parameter logic [2:0] COL_WIN  = DEF_COL_WIN,
   parameter logic [2:0] COL_LOSE = DEF_COL_LOSE
) (
   input logic                   clk,
   input logic                   reset,
   game_display_renderer_if.slave bus
);

   rstate_t      state, state_n;
   game_status_t st_l;
   logic         st_chg;
   logic         start_pend;
   logic         accept, go_fill;

   logic [7:0]   x_l, prev_x_l;
   logic [6:0]   y_l;
   logic         o_l;
   logic [2:0]   fill_col;

   logic         sw_start, sw_valid, sw_last;
   logic [8:0]   sw_ox, sw_oy, sw_w, sw_h, sw_px, sw_py;
   logic [2:0]   pix_col;

   logic [7:0]   vga_x_r;
   logic [6:0]   vga_y_r;
   logic [2:0]   colour_r;
   logic         plot_r, busy_r, overrun_r;

   rect_sweeper u_sweeper (
      .clk    (clk),
      .reset  (reset),
      .start  (sw_start),
      .org_x  (sw_ox),
      .org_y  (sw_oy),
      .size_w (sw_w),
      .size_h (sw_h),
      .px     (sw_px),
      .py     (sw_py),
      .valid  (sw_valid),
      .last   (sw_last)
   );

   // Next state, sweeper launch/geometry and pixel colour
   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      go_fill  = 1'b0;
      sw_start = 1'b0;
      sw_ox    = '0;
      sw_oy    = '0;
      sw_w     = 9'(SCR_W);
      sw_h     = 9'(SCR_H);
      pix_col  = COL_BG;
      st_chg   = (bus.game_status != st_l);
      case (state)
         RS_CLEAR: begin
            sw_start = start_pend;
            if (sw_last) state_n = RS_IDLE;
         end
         RS_IDLE: begin
            // Erase launches in the sync cycle itself, straight off the inputs
            sw_ox = {1'b0, bus.prev_x};
            sw_oy = {2'b00, bus.y};
            sw_w  = 9'(BLOCK_W);
            sw_h  = 9'(BLOCK_H);
            if (st_chg && (bus.game_status == ST_LOSE || bus.game_status == ST_WIN)) begin
               state_n = RS_FILL;
               go_fill = 1'b1;
            end else if (st_chg && bus.game_status == ST_START) begin
               state_n = RS_CLEAR;
            end else if (bus.sync && bus.game_status == ST_PLAY) begin
               state_n  = RS_ERASE;
               accept   = 1'b1;
               sw_start = 1'b1;
            end
         end
         RS_ERASE: begin
            sw_ox = {1'b0, prev_x_l};
            sw_oy = {2'b00, y_l};
            sw_w  = 9'(BLOCK_W);
            sw_h  = 9'(BLOCK_H);
            if (sw_last) state_n = RS_DRAW;
         end
         RS_DRAW: begin
            sw_start = start_pend;
            sw_ox    = {1'b0, x_l};
            sw_oy    = {2'b00, y_l};
            sw_w     = 9'(BLOCK_W);
            sw_h     = 9'(BLOCK_H);
            pix_col  = o_l ? COL_HIT : COL_MISS;
            if (sw_last) state_n = RS_IDLE;
         end
         RS_FILL: begin
            sw_start = start_pend;
            pix_col  = fill_col;
            if (sw_last) state_n = RS_DONE;
         end
         RS_DONE: begin
            if (bus.game_status == ST_START) state_n = RS_CLEAR;
         end
         default: state_n = RS_CLEAR;
      endcase
   end

   // State register; reset always restarts with a full-screen clear
   always_ff @(posedge clk) begin
      if (reset) state <= RS_CLEAR;
      else       state <= state_n;
   end

   // Control: pending sweep launch, last-seen status and sticky overrun
   always_ff @(posedge clk) begin
      if (reset) begin
         start_pend <= 1'b1;
         st_l       <= ST_START;
         overrun_r  <= 1'b0;
      end else begin
         start_pend <= (state_n != state) &&
                       (state_n == RS_CLEAR || state_n == RS_DRAW || state_n == RS_FILL);
         if (state == RS_IDLE || state == RS_DONE) st_l <= bus.game_status;
         if (bus.sync && is_sweep_state(state)) overrun_r <= 1'b1;
      end
   end

   // Latched block position and fill colour
   always_ff @(posedge clk) begin
      if (accept) begin
         x_l      <= bus.x;
         prev_x_l <= bus.prev_x;
         y_l      <= bus.y;
         o_l      <= bus.o;
      end
      if (go_fill) fill_col <= (bus.game_status == ST_WIN) ? COL_WIN : COL_LOSE;
   end

   // Registered pixel stream with off-screen clipping, plus busy
   always_ff @(posedge clk) begin
      if (reset) begin
         vga_x_r  <= '0;
         vga_y_r  <= '0;
         colour_r <= COL_BG;
         plot_r   <= 1'b0;
         busy_r   <= 1'b1;
      end else begin
         plot_r <= sw_valid && (sw_px < 9'(SCR_W)) && (sw_py < 9'(SCR_H));
         busy_r <= sw_valid || is_sweep_state(state_n);
         if (sw_valid) begin
            vga_x_r  <= sw_px[7:0];
            vga_y_r  <= sw_py[6:0];
            colour_r <= pix_col;
         end else begin
            colour_r <= COL_BG;
         end
      end
   end

   assign bus.vga_x   = vga_x_r;
   assign bus.vga_y   = vga_y_r;
   assign bus.colour  = colour_r;
   assign bus.plot    = plot_r;
   assign bus.busy    = busy_r;
   assign bus.overrun = overrun_r;

endmodule
